// File: rtl/load_store_unit_if.sv
// Core/memory-facing signal bundle of the load/store unit.
// The unit connects through the slave view; the core and memory side use the master view.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_cen;
  logic [31:0] mem_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wmask, mem_wdata, mem_cen
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wmask, mem_wdata, mem_cen
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: issues one access to a synchronous data memory and
// returns a formatted, held response (IDLE -> ACCESS -> RESP, errors skip ACCESS).
module load_store_unit #(
  parameter int DMEM_AW = 16
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  off_reg, off_next;
  logic [2:0]  funct3_reg, funct3_next;
  logic        we_reg, we_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;

  logic        out_of_range;
  logic        illegal_f3;
  logic        misaligned;
  logic        req_err;
  logic        accept;
  logic [31:0] sb_data, sh_data;
  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  generate
    if (DMEM_AW < 32) begin : g_range
      assign out_of_range = |bus.req_addr[31:DMEM_AW];
    end else begin : g_full
      assign out_of_range = 1'b0;
    end
  endgenerate

  // Store lane replication and read-lane split.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign sb_data[8*gi +: 8] = bus.req_wdata[7:0];
      assign lane[gi]           = bus.mem_data[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half_lane
      assign sh_data[16*gi +: 16] = bus.req_wdata[15:0];
    end
  endgenerate

  assign illegal_f3 = bus.req_we ? (bus.req_funct3 > 3'b010)
                                 : ((bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11));
  assign misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
                    || ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign req_err    = illegal_f3 | misaligned | out_of_range;
  // Nothing is issued while reset is held, so memory never sees a stray enable.
  assign accept     = (state_reg == IDLE) && bus.req_valid && !reset;

  assign byte_sel = lane[off_reg];
  assign half_sel = off_reg[1] ? bus.mem_data[31:16] : bus.mem_data[15:0];

  always_comb begin
    load_fmt = bus.mem_data;
    case (funct3_reg)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_fmt = {24'd0, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_fmt = {16'd0, half_sel};
      default: load_fmt = bus.mem_data;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    off_next      = off_reg;
    funct3_next   = funct3_reg;
    we_next       = we_reg;
    rdata_next    = rdata_reg;
    err_next      = err_reg;
    bus.req_ready = (state_reg == IDLE);
    bus.rsp_valid = (state_reg == RESP);
    bus.rsp_rdata = rdata_reg;
    bus.rsp_err   = err_reg;
    bus.mem_cen   = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wmask = 4'b0000;
    bus.mem_wdata = 32'd0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          off_next    = bus.req_addr[1:0];
          funct3_next = bus.req_funct3;
          we_next     = bus.req_we;
          if (req_err) begin
            state_next = RESP;
            err_next   = 1'b1;
            rdata_next = 32'd0;
          end else begin
            state_next   = ACCESS;
            bus.mem_cen  = 1'b1;
            bus.mem_addr = {bus.req_addr[31:2], 2'b00};
            if (bus.req_we) begin
              case (bus.req_funct3[1:0])
                2'b00: begin
                  bus.mem_wmask = 4'b0001 << bus.req_addr[1:0];
                  bus.mem_wdata = sb_data;
                end
                2'b01: begin
                  bus.mem_wmask = 4'b0011 << {bus.req_addr[1], 1'b0};
                  bus.mem_wdata = sh_data;
                end
                default: begin
                  bus.mem_wmask = 4'b1111;
                  bus.mem_wdata = bus.req_wdata;
                end
              endcase
            end
          end
        end
      end
      ACCESS: begin
        state_next = RESP;
        err_next   = 1'b0;
        rdata_next = we_reg ? 32'd0 : load_fmt;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
          rdata_next = 32'd0;
          err_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      off_reg    <= 2'd0;
      funct3_reg <= 3'd0;
      we_reg     <= 1'b0;
      rdata_reg  <= 32'd0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      off_reg    <= off_next;
      funct3_reg <= funct3_next;
      we_reg     <= we_next;
      rdata_reg  <= rdata_next;
      err_reg    <= err_next;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a byte-masked synchronous memory model
// behind the unit, stores/loads/errors/backpressure/reset with hand-computed results.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.DMEM_AW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:255];

  always @(posedge clk) begin
    if (bus.mem_cen) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_wmask[i]) mem[bus.mem_addr[9:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      bus.mem_data <= mem[bus.mem_addr[9:2]];
    end
  end

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic access(input string tag, input bit we, input bit [2:0] f3,
                        input bit [31:0] addr, input bit [31:0] wdata, input bit exp_err,
                        input bit [3:0] exp_mask, input bit [31:0] exp_mwdata,
                        input bit [31:0] exp_rdata, input int stall);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    #1;
    check({tag, ".req_ready"}, bus.req_ready, 1);
    check({tag, ".mem_cen"}, bus.mem_cen, {31'd0, !exp_err});
    check({tag, ".mem_wmask"}, bus.mem_wmask, exp_err ? 4'b0000 : exp_mask);
    if (!exp_err) begin
      check({tag, ".mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
      if (we) check({tag, ".mem_wdata"}, bus.mem_wdata, exp_mwdata);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = !exp_err;  // must be ignored while in ACCESS
    @(negedge clk);
    if (!exp_err) begin
      check({tag, ".access_valid"}, bus.rsp_valid, 0);
      check({tag, ".access_cen"}, bus.mem_cen, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    check({tag, ".rsp_valid"}, bus.rsp_valid, 1);
    check({tag, ".rsp_err"}, bus.rsp_err, {31'd0, exp_err});
    check({tag, ".rsp_rdata"}, bus.rsp_rdata, exp_rdata);
    check({tag, ".resp_ready"}, bus.req_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, bus.rsp_valid, 1);
      check({tag, ".hold_err"}, bus.rsp_err, {31'd0, exp_err});
      check({tag, ".hold_rdata"}, bus.rsp_rdata, exp_rdata);
      check({tag, ".hold_ready"}, bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, ".idle_valid"}, bus.rsp_valid, 0);
    check({tag, ".idle_ready"}, bus.req_ready, 1);
    $display("txn %-8s we=%0d f3=%03b addr=0x%08h rdata=0x%08h err=%0d",
             tag, we, f3, addr, bus.rsp_rdata, exp_err);
  endtask

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    // A request presented under reset must not reach memory.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h100; bus.req_wdata = 32'h12345678;
    #1;
    check("rst.req_ready", bus.req_ready, 1);
    check("rst.rsp_valid", bus.rsp_valid, 0);
    check("rst.rsp_rdata", bus.rsp_rdata, 0);
    check("rst.rsp_err", bus.rsp_err, 0);
    check("rst.mem_cen", bus.mem_cen, 0);
    check("rst.mem_wmask", bus.mem_wmask, 0);
    check("rst.mem_wdata", bus.mem_wdata, 0);
    check("rst.mem_addr", bus.mem_addr, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b0;

    access("SW_init", 1, 3'b010, 32'h100, 32'h80FF7F01, 0, 4'b1111, 32'h80FF7F01, 32'h0, 0);
    access("LB101",   0, 3'b000, 32'h101, 32'h0, 0, 4'b0000, 32'h0, 32'h0000007F, 0);
    access("LB102",   0, 3'b000, 32'h102, 32'h0, 0, 4'b0000, 32'h0, 32'hFFFFFFFF, 0);
    access("LBU102",  0, 3'b100, 32'h102, 32'h0, 0, 4'b0000, 32'h0, 32'h000000FF, 0);
    access("LH102",   0, 3'b001, 32'h102, 32'h0, 0, 4'b0000, 32'h0, 32'hFFFF80FF, 0);
    access("LHU102",  0, 3'b101, 32'h102, 32'h0, 0, 4'b0000, 32'h0, 32'h000080FF, 0);
    access("LW100",   0, 3'b010, 32'h100, 32'h0, 0, 4'b0000, 32'h0, 32'h80FF7F01, 5);
    access("LB103",   0, 3'b000, 32'h103, 32'h0, 0, 4'b0000, 32'h0, 32'hFFFFFF80, 0);
    access("LH100",   0, 3'b001, 32'h100, 32'h0, 0, 4'b0000, 32'h0, 32'h00007F01, 0);

    access("E_LW102", 0, 3'b010, 32'h102,   32'h0, 1, 4'b0000, 32'h0, 32'h0, 0);
    access("E_SH101", 1, 3'b001, 32'h101,   32'hBEEF, 1, 4'b0000, 32'h0, 32'h0, 0);
    access("E_LBoor", 0, 3'b000, 32'h10000, 32'h0, 1, 4'b0000, 32'h0, 32'h0, 0);
    access("E_L011",  0, 3'b011, 32'h100,   32'h0, 1, 4'b0000, 32'h0, 32'h0, 0);
    access("E_S100",  1, 3'b100, 32'h100,   32'h55, 1, 4'b0000, 32'h0, 32'h0, 2);
    access("LW_keep", 0, 3'b010, 32'h100, 32'h0, 0, 4'b0000, 32'h0, 32'h80FF7F01, 0);

    access("SW100",   1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
    access("SB103",   1, 3'b000, 32'h103, 32'h123456A5, 0, 4'b1000, 32'hA5A5A5A5, 32'h0, 0);
    access("SH102",   1, 3'b001, 32'h102, 32'h0000BEEF, 0, 4'b1100, 32'hBEEFBEEF, 32'h0, 0);
    access("SB101",   1, 3'b000, 32'h101, 32'h0000005A, 0, 4'b0010, 32'h5A5A5A5A, 32'h0, 0);
    access("LW_rb",   0, 3'b010, 32'h100, 32'h0, 0, 4'b0000, 32'h0, 32'hBEEF5AEF, 0);

    // Reset in the middle of an LW's ACCESS cycle abandons the response.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h100;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rstmid.rsp_valid", bus.rsp_valid, 0);
    check("rstmid.req_ready", bus.req_ready, 1);
    check("rstmid.rsp_rdata", bus.rsp_rdata, 0);
    check("rstmid.mem_cen", bus.mem_cen, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstmid.hold_valid", bus.rsp_valid, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("rstmid.post_valid", bus.rsp_valid, 0);
    check("rstmid.post_ready", bus.req_ready, 1);
    $display("txn reset mid-ACCESS of LW 0x100 abandoned");

    access("SW104",   1, 3'b010, 32'h104, 32'h11223344, 0, 4'b1111, 32'h11223344, 32'h0, 0);
    access("LW104",   0, 3'b010, 32'h104, 32'h0, 0, 4'b0000, 32'h0, 32'h11223344, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
